// File: rtl/lcd_reg_arbiter_if.sv
// Bundle of the requester-side and transceiver-side signals of lcd_reg_arbiter.
// Signal prefixes are from the arbiter's point of view: i_* flows into it, o_* out of it.
//   slave  : the arbiter itself
//   master : the environment (requesters plus LCD serial transceiver)
interface lcd_reg_arbiter_if;
  // Requester 0 / 1
  logic       i_req0, i_req1;
  logic       i_reqWrite0, i_reqWrite1;
  logic [6:0] i_reqAddr0, i_reqAddr1;
  logic [7:0] i_reqData0, i_reqData1;
  logic       o_ack0, o_ack1;
  logic       o_err0, o_err1;
  logic [7:0] o_rdData0, o_rdData1;
  // LCD serial transceiver
  logic       o_txBegin, o_rxBegin;
  logic [6:0] o_address;
  logic [7:0] o_txData;
  logic       i_txDone, i_rxDone;
  logic [7:0] i_rxData;
  // Status
  logic       o_busy;

  modport slave (
    input  i_req0, i_req1, i_reqWrite0, i_reqWrite1, i_reqAddr0, i_reqAddr1,
    input  i_reqData0, i_reqData1, i_txDone, i_rxDone, i_rxData,
    output o_ack0, o_ack1, o_err0, o_err1, o_rdData0, o_rdData1,
    output o_txBegin, o_rxBegin, o_address, o_txData, o_busy
  );

  modport master (
    output i_req0, i_req1, i_reqWrite0, i_reqWrite1, i_reqAddr0, i_reqAddr1,
    output i_reqData0, i_reqData1, i_txDone, i_rxDone, i_rxData,
    input  o_ack0, o_ack1, o_err0, o_err1, o_rdData0, o_rdData1,
    input  o_txBegin, o_rxBegin, o_address, o_txData, o_busy
  );
endinterface

// File: rtl/lcd_reg_arbiter.sv
// Two-requester round-robin arbiter in front of an LCD serial register transceiver.
// Each transaction runs IDLE -> ISSUE -> WAIT -> DONE -> IDLE; every output is a flop.
// Ports:
//   i_clock        sole clock, rising edge
//   i_reset        synchronous, active-high reset
//   bus (slave)    requester handshakes (req/write/addr/data in, ack/err/rdData out),
//                  transceiver start pulses, address/write data, done pulses, read data,
//                  and o_busy (high outside IDLE)
// Parameter:
//   TIMEOUT_CYCLES cycles spent in WAIT before a transaction is abandoned with error
module lcd_reg_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic              i_clock,
  input logic              i_reset,
  lcd_reg_arbiter_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} stateT;

  stateT           stateQ, stateD;
  logic            grantQ, grantD;           // requester owning the transaction
  logic            lastServedQ, lastServedD;
  logic            writeQ, writeD;
  logic [6:0]      addrQ, addrD;
  logic [7:0]      txDataQ, txDataD;
  logic [CntW-1:0] cntQ, cntD;
  logic            txBeginQ, txBeginD;
  logic            rxBeginQ, rxBeginD;
  logic            ack0Q, ack0D, ack1Q, ack1D;
  logic            err0Q, err0D, err1Q, err1D;
  logic [7:0]      rdData0Q, rdData0D, rdData1Q, rdData1D;
  logic            busyQ, busyD;

  logic            pick;
  logic            pickWrite;
  logic [6:0]      pickAddr;
  logic [7:0]      pickData;
  logic            doneHit;
  logic            finish;
  logic            timedOut;

  always_comb begin
    stateD      = stateQ;
    grantD      = grantQ;
    lastServedD = lastServedQ;
    writeD      = writeQ;
    addrD       = addrQ;
    txDataD     = txDataQ;
    cntD        = cntQ;
    rdData0D    = rdData0Q;
    rdData1D    = rdData1Q;
    txBeginD    = 1'b0;
    rxBeginD    = 1'b0;
    finish      = 1'b0;
    timedOut    = 1'b0;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    pick      = bus.i_req1 & (~bus.i_req0 | ~lastServedQ);
    pickWrite = pick ? bus.i_reqWrite1 : bus.i_reqWrite0;
    pickAddr  = pick ? bus.i_reqAddr1  : bus.i_reqAddr0;
    pickData  = pick ? bus.i_reqData1  : bus.i_reqData0;

    // Only the done line matching the transaction type can complete it.
    doneHit = writeQ ? bus.i_txDone : bus.i_rxDone;

    unique case (stateQ)
      StIdle: begin
        if (bus.i_req0 | bus.i_req1) begin
          stateD   = StIssue;
          grantD   = pick;
          writeD   = pickWrite;
          addrD    = pickAddr;
          txDataD  = pickWrite ? pickData : 8'h00;
          txBeginD = pickWrite;
          rxBeginD = ~pickWrite;
        end
      end
      StIssue: begin
        stateD = StWait;
        cntD   = '0;
      end
      StWait: begin
        // A done in the timeout cycle still counts as success.
        if (doneHit) begin
          stateD = StDone;
          finish = 1'b1;
          if (!writeQ) begin
            if (grantQ) rdData1D = bus.i_rxData;
            else        rdData0D = bus.i_rxData;
          end
        end else if (cntQ == CntLast) begin
          stateD   = StDone;
          finish   = 1'b1;
          timedOut = 1'b1;
        end else begin
          cntD = cntQ + CntW'(1);
        end
      end
      StDone: begin
        stateD      = StIdle;
        lastServedD = grantQ;
      end
      default: stateD = StIdle;
    endcase

    ack0D = finish & ~grantQ;
    ack1D = finish & grantQ;
    err0D = timedOut & ~grantQ;
    err1D = timedOut & grantQ;
    busyD = (stateD != StIdle);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      stateQ      <= StIdle;
      grantQ      <= 1'b0;
      lastServedQ <= 1'b1;
      writeQ      <= 1'b0;
      addrQ       <= 7'h00;
      txDataQ     <= 8'h00;
      cntQ        <= '0;
      txBeginQ    <= 1'b0;
      rxBeginQ    <= 1'b0;
      ack0Q       <= 1'b0;
      ack1Q       <= 1'b0;
      err0Q       <= 1'b0;
      err1Q       <= 1'b0;
      rdData0Q    <= 8'h00;
      rdData1Q    <= 8'h00;
      busyQ       <= 1'b0;
    end else begin
      stateQ      <= stateD;
      grantQ      <= grantD;
      lastServedQ <= lastServedD;
      writeQ      <= writeD;
      addrQ       <= addrD;
      txDataQ     <= txDataD;
      cntQ        <= cntD;
      txBeginQ    <= txBeginD;
      rxBeginQ    <= rxBeginD;
      ack0Q       <= ack0D;
      ack1Q       <= ack1D;
      err0Q       <= err0D;
      err1Q       <= err1D;
      rdData0Q    <= rdData0D;
      rdData1Q    <= rdData1D;
      busyQ       <= busyD;
    end
  end

  assign bus.o_txBegin = txBeginQ;
  assign bus.o_rxBegin = rxBeginQ;
  assign bus.o_address = addrQ;
  assign bus.o_txData  = txDataQ;
  assign bus.o_ack0    = ack0Q;
  assign bus.o_ack1    = ack1Q;
  assign bus.o_err0    = err0Q;
  assign bus.o_err1    = err1Q;
  assign bus.o_rdData0 = rdData0Q;
  assign bus.o_rdData1 = rdData1Q;
  assign bus.o_busy    = busyQ;

endmodule

// File: doc/lcd_reg_arbiter.md
LCD_REG_ARBITER -- requirements
Module: lcd_reg_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096: cycles allowed in WAIT before a transaction is abandoned.
REQ-002 SHALL have port i_clock  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port i_reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports i_req0/i_req1  in  1 each  request, held high until the matching ack.
REQ-005 SHALL have ports i_reqWrite0/i_reqWrite1  in  1 each  1 = register write, 0 = register read.
REQ-006 SHALL have ports i_reqAddr0/i_reqAddr1  in  7 each  LCD register address.
REQ-007 SHALL have ports i_reqData0/i_reqData1  in  8 each  write data; ignored for reads.
REQ-008 SHALL have ports o_ack0/o_ack1  out  1 each  one-cycle completion pulse.
REQ-009 SHALL have ports o_err0/o_err1  out  1 each  timeout flag, valid only while the matching ack is high.
REQ-010 SHALL have ports o_rdData0/o_rdData1  out  8 each  last read result per requester.
REQ-011 SHALL have ports o_txBegin/o_rxBegin  out  1 each  start pulses to the LCD serial transceiver.
REQ-012 SHALL have ports o_address  out  7 and o_txData  out  8, the transceiver address and write data.
REQ-013 SHALL have ports i_txDone/i_rxDone  in  1 each and i_rxData  in  8, the transceiver completion pulses and read data.
REQ-014 SHALL have port o_busy  out  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, with all outputs registered.
REQ-016 IDLE: on an edge with any i_reqN high, SHALL grant one requester, latch its write/addr/data into internal registers and enter ISSUE.
REQ-017 Arbitration SHALL be round-robin: when both request, grant the requester not served last; after reset, last-served = 1, so requester 0 wins the first tie.
REQ-018 ISSUE SHALL last exactly one cycle, with o_txBegin=1 for a write or o_rxBegin=1 for a read, never both; it then enters WAIT with the timeout counter cleared.
REQ-019 Latency SHALL be: request sampled high at edge k gives begin high in cycle k+1.
REQ-020 o_address and o_txData SHALL hold the latched values from ISSUE through DONE and are don't-care in IDLE; o_txData SHALL be 0 for reads.
REQ-021 WAIT, write: SHALL exit to DONE on i_txDone, and SHALL ignore i_rxDone.
REQ-022 WAIT, read: SHALL exit to DONE on i_rxDone and capture i_rxData in the same edge, and SHALL ignore i_txDone.
REQ-023 WAIT: the counter SHALL increment each cycle; at TIMEOUT_CYCLES-1 with no matching done, SHALL go to DONE with error set.
REQ-024 If the matching done and the timeout occur in the same cycle, done SHALL win and no error SHALL be flagged.
REQ-025 DONE SHALL last one cycle: o_ackN=1 for the granted requester only; o_errN=1 if timed out.
REQ-026 On a successful read, o_rdDataN SHALL update at DONE entry; it SHALL be unchanged on writes and on timeouts.
REQ-027 DONE SHALL update last-served and return to IDLE.
REQ-028 A request still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-029 Done pulses arriving in IDLE, ISSUE or DONE (e.g. late after a timeout) SHALL be ignored.
REQ-030 Changes to a granted requester's addr/data/write after grant SHALL NOT affect the transaction in flight.
REQ-031 A non-granted request SHALL wait unserved; no request SHALL be dropped while i_reqN stays high.

Reset
REQ-032 i_reset high at an edge SHALL force IDLE with: all begin/ack/err outputs 0, o_busy 0, o_address 0, o_txData 0, o_rdData0/1 0, counter 0, last-served 1.
REQ-033 Reset SHALL override every state, including mid-WAIT; the abandoned transaction SHALL produce no ack, and its later done pulse SHALL be ignored per REQ-029.

Verification
REQ-034 Req0 write addr 0x78 data 0x5A, i_txDone 10 cycles after begin -> o_txBegin one cycle, o_address=0x78, o_txData=0x5A, o_ack0 one cycle, o_err0=0.
REQ-035 Req1 read addr 0x78, i_rxDone with i_rxData=0x20 -> o_rxBegin one cycle, o_rdData1=0x20 at ack, o_rdData0 unchanged.
REQ-036 Both requests asserted continuously after reset -> grant order 0,1,0,1; each ack separated by a full transaction; no starvation.
REQ-037 Read with no done, TIMEOUT_CYCLES=16 -> ack with err exactly 16 cycles after WAIT entry; o_rdData unchanged; a stray i_rxDone 3 cycles later is ignored.
REQ-038 Reset asserted in WAIT, then i_txDone arrives -> outputs at reset values, no ack, FSM stays IDLE; the next request is served normally, with requester 0 winning a tie.
